// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader and its readback packer.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  function automatic int ccff_nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits needed to hold the value n (at least one).
  function automatic int ccff_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_tail_packer.sv
// Serial-to-parallel packer for bits leaving the chain tail; emits MSB-first words and a
// left-aligned, zero-padded final partial word once CHAIN_LEN bits have been sampled.
module ccff_tail_packer
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              sample_i,
  input  logic              bit_i,
  output logic              rd_valid_o,
  output logic [WORD_W-1:0] rd_data_o
);

  localparam int CNT_W = ccff_cnt_w(CHAIN_LEN);
  localparam int WB_W  = ccff_cnt_w(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  WORD_LAST = WB_W'(WORD_W - 1);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WB_W-1:0]   wbit_q;
  logic [CNT_W-1:0]  tot_q;
  logic              rd_valid_q;
  logic [WORD_W-1:0] rd_data_q;
  logic              word_end, last_bit;

  assign acc_d    = (acc_q << 1) | WORD_W'(bit_i);
  assign word_end = (wbit_q == WORD_LAST);
  assign last_bit = (tot_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      wbit_q     <= '0;
      tot_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (clr_i) begin
        acc_q  <= '0;
        wbit_q <= '0;
        tot_q  <= '0;
      end else if (sample_i) begin
        if (word_end || last_bit) begin
          // Short final word is left-aligned by the number of unused slots.
          rd_valid_q <= 1'b1;
          rd_data_q  <= acc_d << (WORD_LAST - wbit_q);
          acc_q      <= '0;
          wbit_q     <= '0;
        end else begin
          acc_q  <= acc_d;
          wbit_q <= wbit_q + 1'b1;
        end
        tot_q <= last_bit ? '0 : tot_q + 1'b1;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a ccff configuration chain from a word stream, one registered bit per enabled shift.
// Optional tail readback of the previous configuration is built when CCFF_READBACK_EN is defined.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic [1:0]        dbg_state
);

  // Stream handshake: a word transfers on any prog_clk edge where in_valid && in_ready;
  // in_ready is high only in LOAD and the word is held until it does.

  localparam int CNT_W = ccff_cnt_w(CHAIN_LEN);
  localparam int WB_W  = ccff_cnt_w(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  WORD_LAST = WB_W'(WORD_W - 1);

  ccff_state_e       state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]   wbit_q;
  logic              head_q, shift_en_q, in_ready_q, busy_q, done_q, err_q;

  assign bit_cnt_d = bit_cnt_q + 1'b1;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      wbit_q     <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Chain contents are left as is; only the sequencing stops.
        state_q    <= IDLE;
        shift_en_q <= 1'b0;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b0;
        err_q      <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= LOAD;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              err_q      <= 1'b0;
              bit_cnt_q  <= '0;
            end
          end
          LOAD: begin
            shift_en_q <= 1'b0;
            if (in_valid) begin
              sreg_q     <= in_data;
              wbit_q     <= '0;
              in_ready_q <= 1'b0;
              state_q    <= SHIFT;
            end
          end
          SHIFT: begin
            head_q     <= sreg_q[WORD_W-1];
            shift_en_q <= 1'b1;
            sreg_q     <= sreg_q << 1;
            bit_cnt_q  <= bit_cnt_d;
            wbit_q     <= wbit_q + 1'b1;
            // Chain length wins over word end, so the last word's low bits are dropped.
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else if (wbit_q == WORD_LAST) begin
              state_q    <= LOAD;
              in_ready_q <= 1'b1;
            end
          end
          DONE: begin
            shift_en_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

`ifdef CCFF_READBACK_EN
  logic pack_clr;
  assign pack_clr = (state_q == IDLE) && start && !abort;

  ccff_tail_packer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_packer (
    .clk        (prog_clk),
    .rst_n      (pReset_n),
    .clr_i      (pack_clr),
    .sample_i   (shift_en_q),
    .bit_i      (ccff_tail),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rd_valid    = 1'b0;
  assign rd_data     = '0;
`endif

endmodule
